// File: rtl/nabp_pkg.sv
// Shared definitions for the NABP folded tan/cot shifter LUT.
//   - default geometry (angle count, angle code width, base width, fraction bits)
//   - fold_t: result of folding an angle code onto the 0..45 deg octant
//   - tan_rom_entry(): ROM contents T[i] = round(tan(i*180/N deg) * 2^FRAC)
//   - fold_angle(): octant folding of an angle code
package nabp_pkg;

  localparam int NABP_N_ANGLES = 180;
  localparam int NABP_ANGLE_W  = 8;
  localparam int NABP_DATA_W   = 16;
  localparam int NABP_FRAC_W   = 14;

  // Wide enough for any octant index the angle code width can produce.
  localparam int FOLD_IDX_W = 16;

  typedef struct packed {
    logic [FOLD_IDX_W-1:0] idx;
    logic                  neg;
    logic                  swap;
    logic                  err;
  } fold_t;

  // Magnitude is rounded half-up; all entries are non-negative (0..45 deg).
  function automatic int tan_rom_entry(input int i, input int n_angles, input int frac_w);
    real ang;
    real v;
    ang = real'(i) * 3.14159265358979323846 / real'(n_angles);
    v   = $tan(ang) * real'(1 << frac_w);
    return $rtoi(v + 0.5);
  endfunction

  // Maps 0..180 deg onto the first octant: beyond 45 deg the cotangent of the
  // mirrored angle is used (swap), and the second quadrant negates the base.
  function automatic fold_t fold_angle(input int a, input int n_angles);
    fold_t f;
    int    q;
    q = n_angles / 4;
    f = '0;
    if (a < q) begin
      f.idx = FOLD_IDX_W'(a);
    end else if (a < 2 * q) begin
      f.idx  = FOLD_IDX_W'(2 * q - a);
      f.swap = 1'b1;
    end else if (a < 3 * q) begin
      f.idx  = FOLD_IDX_W'(a - 2 * q);
      f.neg  = 1'b1;
      f.swap = 1'b1;
    end else if (a < 4 * q) begin
      f.idx = FOLD_IDX_W'(4 * q - a);
      f.neg = 1'b1;
    end else begin
      f.err = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/nabp_rr_arbiter.sv
// Round-robin arbiter with priority pointer.
//   clk, reset : clock, async active-high reset (pointer -> channel 0)
//   req        : per-channel request
//   grant      : one-hot grant, combinational from req and pointer, 0 in reset
// The pointer moves to the channel after the last granted one.
module nabp_rr_arbiter #(
  parameter int N_CH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic [CH_W-1:0] gidx;
  logic            found;
  int              c;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    gidx  = '0;
    c     = 0;
    // Scan starting at the pointer; first active request wins.
    for (int o = 0; o < N_CH; o++) begin
      c = (int'(ptr_q) + o) % N_CH;
      if (!found && req[c]) begin
        found = 1'b1;
        gidx  = CH_W'(c);
      end
    end
    if (found && !reset) begin
      grant[gidx] = 1'b1;
      ptr_d       = (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/nabp_folded_shifter_lut.sv
// Folded tan/cot accumulator-base lookup shared by N_CH shifter channels.
//   clk, reset : clock, async active-high reset
//   req_valid  : per-channel lookup request
//   req_angle  : per-channel angle code, channel k at [k*ANGLE_W +: ANGLE_W]
//   req_ready  : one-hot round-robin grant (request accepted when valid & ready)
//   res_valid  : one-cycle strobe per accepted request, 3 cycles after request
//   res_ch     : channel of the result
//   res_base   : signed tan (swap=0) or cot (swap=1) base, FRAC_W fraction bits
//   res_swap   : accumulate along y instead of x
//   res_err    : angle code was out of range (base and swap forced to 0)
// Result fields hold their value while res_valid is low.
module nabp_folded_shifter_lut
  import nabp_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int N_ANGLES = NABP_N_ANGLES,
  parameter int ANGLE_W  = NABP_ANGLE_W,
  parameter int DATA_W   = NABP_DATA_W,
  parameter int FRAC_W   = NABP_FRAC_W,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           req_valid,
  input  logic [N_CH*ANGLE_W-1:0]   req_angle,
  output logic [N_CH-1:0]           req_ready,
  output logic                      res_valid,
  output logic [CH_W-1:0]           res_ch,
  output logic signed [DATA_W-1:0]  res_base,
  output logic                      res_swap,
  output logic                      res_err
);

  localparam int Q     = N_ANGLES / 4;
  localparam int IDX_W = $clog2(Q + 1);

  function automatic logic signed [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                          input logic neg);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  logic [DATA_W-1:0] rom [Q+1];

  for (genvar g = 0; g <= Q; g++) begin : g_rom
    assign rom[g] = DATA_W'(tan_rom_entry(g, N_ANGLES, FRAC_W));
  end

  logic [N_CH-1:0]    grant;
  logic               accept;
  logic [CH_W-1:0]    acc_ch;
  logic [ANGLE_W-1:0] acc_angle;

  nabp_rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    acc_ch    = '0;
    acc_angle = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant[k]) begin
        acc_ch    = CH_W'(k);
        acc_angle = req_angle[k*ANGLE_W +: ANGLE_W];
      end
    end
  end

  // ---- stage 1: granted channel and fold result ----
  logic            vld_p1_q, vld_p1_d;
  logic [CH_W-1:0] ch_p1_q, ch_p1_d;
  fold_t           fold_p1_q, fold_p1_d;

  always_comb begin
    vld_p1_d  = accept;
    ch_p1_d   = acc_ch;
    fold_p1_d = fold_angle(int'(acc_angle), N_ANGLES);
  end

  // ---- stage 2: registered ROM read ----
  logic              vld_p2_q, vld_p2_d;
  logic [CH_W-1:0]   ch_p2_q, ch_p2_d;
  logic [DATA_W-1:0] rom_p2_q, rom_p2_d;
  logic              neg_p2_q, neg_p2_d;
  logic              swap_p2_q, swap_p2_d;
  logic              err_p2_q, err_p2_d;

  always_comb begin
    vld_p2_d  = vld_p1_q;
    ch_p2_d   = ch_p1_q;
    neg_p2_d  = fold_p1_q.neg;
    swap_p2_d = fold_p1_q.swap & ~fold_p1_q.err;
    err_p2_d  = fold_p1_q.err;
    // Index is always <= Q for in-range angles; the guard keeps the read in bounds.
    if (fold_p1_q.idx < FOLD_IDX_W'(Q + 1)) begin
      rom_p2_d = rom[fold_p1_q.idx[IDX_W-1:0]];
    end else begin
      rom_p2_d = '0;
    end
  end

  // ---- stage 3: sign application and output registers ----
  logic                     res_valid_q, res_valid_d;
  logic [CH_W-1:0]          res_ch_q, res_ch_d;
  logic signed [DATA_W-1:0] res_base_q, res_base_d;
  logic                     res_swap_q, res_swap_d;
  logic                     res_err_q, res_err_d;

  always_comb begin
    res_valid_d = vld_p2_q;
    res_ch_d    = res_ch_q;
    res_base_d  = res_base_q;
    res_swap_d  = res_swap_q;
    res_err_d   = res_err_q;
    if (vld_p2_q) begin
      res_ch_d   = ch_p2_q;
      res_swap_d = swap_p2_q;
      res_err_d  = err_p2_q;
      res_base_d = err_p2_q ? '0 : apply_sign(rom_p2_q, neg_p2_q);
    end
  end

  // Control and output state: cleared by reset so in-flight work is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_base_q  <= '0;
      res_swap_q  <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_base_q  <= res_base_d;
      res_swap_q  <= res_swap_d;
      res_err_q   <= res_err_d;
    end
  end

  // Pipeline data: qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    ch_p1_q   <= ch_p1_d;
    fold_p1_q <= fold_p1_d;
    ch_p2_q   <= ch_p2_d;
    rom_p2_q  <= rom_p2_d;
    neg_p2_q  <= neg_p2_d;
    swap_p2_q <= swap_p2_d;
    err_p2_q  <= err_p2_d;
  end

  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_base  = res_base_q;
  assign res_swap  = res_swap_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_nabp_folded_shifter_lut.sv
// Directed bench for nabp_folded_shifter_lut (N_CH=2, default geometry).
module tb_nabp_folded_shifter_lut;

  logic               clk;
  logic               reset;
  logic [1:0]         req_valid;
  logic [15:0]        req_angle;
  logic [1:0]         req_ready;
  logic               res_valid;
  logic [0:0]         res_ch;
  logic signed [15:0] res_base;
  logic               res_swap;
  logic               res_err;

  int n_chk = 0;
  int n_err = 0;

  nabp_folded_shifter_lut #(
    .N_CH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_base  (res_base),
    .res_swap  (res_swap),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Golden model straight from the trig definition, no folding.
  function automatic int gold_base(input int a);
    real th;
    real r;
    th = real'(a) * 3.14159265358979323846 / 180.0;
    if (a < 45 || a >= 135) r = $tan(th) * 16384.0;
    else                    r = $cos(th) / $sin(th) * 16384.0;
    if (r < 0.0) return -$rtoi(-r + 0.5);
    return $rtoi(r + 0.5);
  endfunction

  function automatic int gold_swap(input int a);
    return (a >= 45 && a < 135) ? 1 : 0;
  endfunction

  // Single request on one channel; result expected in the third cycle after it.
  task automatic send_one(input int ch, input int ang, input int eb, input int es,
                          input int ee, input string tag);
    int held;
    @(negedge clk);
    req_valid = 2'(1 << ch);
    req_angle[ch*8 +: 8] = 8'(ang);
    #1;
    check({tag, "_rdy"}, req_ready, 1 << ch);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check({tag, "_early"}, res_valid, 0);
    @(negedge clk);
    check({tag, "_vld"}, res_valid, 1);
    check({tag, "_ch"}, res_ch, ch);
    check({tag, "_base"}, res_base, eb);
    check({tag, "_swap"}, res_swap, es);
    check({tag, "_err"}, res_err, ee);
    held = res_base;
    @(negedge clk);
    check({tag, "_once"}, res_valid, 0);
    check({tag, "_hold"}, res_base, held);
  endtask

  int q[$];
  int nres;
  int a;

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_angle = '0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_base", res_base, 0);
    check("rst_res_ch", res_ch, 0);
    check("rst_res_swap", res_swap, 0);
    check("rst_res_err", res_err, 0);
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;

    // Both channels requesting every cycle: alternate grants and in-order results.
    @(negedge clk);
    req_angle = {8'd60, 8'd30};
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i < 4) check($sformatf("rr_gnt%0d", i), req_ready, (i % 2 == 0) ? 1 : 2);
      if (i == 4) req_valid = 2'b00;
      if (i >= 3 && i <= 6) begin
        check($sformatf("rr_vld%0d", i), res_valid, 1);
        check($sformatf("rr_ch%0d", i), res_ch, (i - 3) % 2);
        check($sformatf("rr_base%0d", i), res_base, 9459);
        check($sformatf("rr_swap%0d", i), res_swap, (i - 3) % 2);
      end
      if (i == 7) check("rr_drain", res_valid, 0);
      @(negedge clk);
    end

    send_one(0, 30, 9459, 0, 0, "a30");
    send_one(0, 60, 9459, 1, 0, "a60");
    send_one(0, 120, -9459, 1, 0, "a120");
    send_one(0, 150, -9459, 0, 0, "a150");
    send_one(0, 135, -16384, 0, 0, "a135");
    send_one(0, 45, 16384, 1, 0, "a45");
    send_one(0, 90, 0, 1, 0, "a90");
    send_one(0, 0, 0, 0, 0, "a0");
    send_one(1, 200, 0, 0, 1, "oor200");
    send_one(1, 30, 9459, 0, 0, "after_oor");
    send_one(0, 179, gold_base(179), 0, 0, "a179");

    // Pointer now sits on ch1: both requesting grants ch1 then ch0, then reset.
    @(negedge clk);
    req_angle = {8'd60, 8'd30};
    req_valid = 2'b11;
    #1;
    check("mid_gnt0", req_ready, 2);
    @(negedge clk);
    #1;
    check("mid_gnt1", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_base", res_base, 0);
    check("mid_rst_valid", res_valid, 0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;
    nres = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid) nres++;
    end
    check("mid_discard", nres, 0);
    req_valid = 2'b11;
    #1;
    check("post_rst_gnt", req_ready, 1);
    @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) @(negedge clk);

    // Full sweep on ch0 against the golden model.
    nres = 0;
    for (int cyc = 0; cyc < 190; cyc++) begin
      @(negedge clk);
      if (res_valid) begin
        nres++;
        if (q.size() == 0) begin
          check("sweep_extra", 1, 0);
        end else begin
          a = q.pop_front();
          check($sformatf("sweep_base_%0d", a), res_base, gold_base(a));
          check($sformatf("sweep_swap_%0d", a), res_swap, gold_swap(a));
          check($sformatf("sweep_err_%0d", a), res_err, 0);
          check($sformatf("sweep_ch_%0d", a), res_ch, 0);
        end
      end
      if (cyc < 180) begin
        req_valid = 2'b01;
        req_angle[7:0] = 8'(cyc);
      end else begin
        req_valid = 2'b00;
      end
      #1;
      if (req_ready[0]) q.push_back(cyc);
    end
    check("sweep_count", nres, 180);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
